// File: rtl/led_ctrl_pkg.sv
// Shared constants for the Avalon-MM LED controller: register map,
// channel modes and field positions.
package led_ctrl_pkg;

  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_PRESCALE = 1;
  localparam int ADDR_BLINK    = 2;
  localparam int ADDR_STATUS   = 3;
  localparam int ADDR_CH0      = 4;

  localparam int CTRL_EN_BIT      = 0;
  localparam int STATUS_PWM_LSB   = 0;
  localparam int STATUS_PHASE_BIT = 16;
  localparam int CH_MODE_LSB      = 0;
  localparam int CH_DUTY_LSB      = 2;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } led_mode_e;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode/duty register and computes the next LED
// level from the shared PWM counter and blink phase.
module led_channel
  import led_ctrl_pkg::*;
#(
  parameter int DUTY_W = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              i_wr,
  input  logic [DUTY_W+1:0] i_wdata,
  input  logic              i_en,
  input  logic [DUTY_W-1:0] i_pwm_cnt,
  input  logic              i_blink_phase,
  output logic [31:0]       o_rdata,
  output logic              o_led_next
);

  led_mode_e         r_mode;
  logic [DUTY_W-1:0] r_duty;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_mode <= MODE_OFF;
      r_duty <= '0;
    end else if (i_wr) begin
      r_mode <= led_mode_e'(i_wdata[CH_MODE_LSB +: 2]);
      r_duty <= i_wdata[CH_DUTY_LSB +: DUTY_W];
    end
  end

  // A disabled controller overrides every mode, including "on".
  always_comb begin
    o_led_next = 1'b0;
    if (i_en) begin
      case (r_mode)
        MODE_OFF:   o_led_next = 1'b0;
        MODE_ON:    o_led_next = 1'b1;
        MODE_BLINK: o_led_next = i_blink_phase;
        MODE_PWM:   o_led_next = (i_pwm_cnt < r_duty);
        default:    o_led_next = 1'b0;
      endcase
    end
  end

  always_comb begin
    o_rdata = '0;
    o_rdata[CH_MODE_LSB +: 2]      = r_mode;
    o_rdata[CH_DUTY_LSB +: DUTY_W] = r_duty;
  end

endmodule

// File: rtl/avmm_led_pwm_ctrl.sv
// Avalon-MM LED controller: register decode, tick prescaler, shared PWM and
// blink counters, N_CH channel instances and a 1-cycle-latency read port.
module avmm_led_pwm_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_CH         = 8,
  parameter int DUTY_W       = 8,
  parameter int PRESCALE_RST = 49,
  parameter int ADDR_W       = 5
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [N_CH-1:0]   leds_export
);

  logic              r_en;
  logic [15:0]       r_prescale;
  logic [15:0]       r_blink_half;
  logic [15:0]       r_presc_cnt;
  logic [DUTY_W-1:0] r_pwm_cnt;
  logic [15:0]       r_blink_cnt;
  logic              r_blink_phase;

  logic              w_wr_ctrl;
  logic              w_wr_prescale;
  logic              w_wr_blink;
  logic              w_tick;
  logic [N_CH-1:0]   w_ch_wr;
  logic [N_CH-1:0]   w_led_next;
  logic [N_CH-1:0][31:0] w_ch_rdata;
  logic [31:0]       w_rd_data;
  logic              w_unused_wdata;

  assign w_unused_wdata = ^avs_writedata;

  assign w_wr_ctrl     = avs_write && (avs_address == ADDR_W'(ADDR_CTRL));
  assign w_wr_prescale = avs_write && (avs_address == ADDR_W'(ADDR_PRESCALE));
  assign w_wr_blink    = avs_write && (avs_address == ADDR_W'(ADDR_BLINK));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_en         <= 1'b0;
      r_prescale   <= 16'(PRESCALE_RST);
      r_blink_half <= '0;
    end else begin
      if (w_wr_ctrl)     r_en         <= avs_writedata[CTRL_EN_BIT];
      if (w_wr_prescale) r_prescale   <= avs_writedata[15:0];
      if (w_wr_blink)    r_blink_half <= avs_writedata[15:0];
    end
  end

  assign w_tick = r_en && (r_presc_cnt == r_prescale);

  always_ff @(posedge clk_clk) begin
    if (reset_reset || !r_en) begin
      r_presc_cnt   <= '0;
      r_pwm_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      // A lowered PRESCALE below the running count restarts the period
      // instead of letting the counter run up to 2^16.
      if (w_tick || (r_presc_cnt > r_prescale)) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + 16'd1;
      end
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
        // >= also recovers cleanly when BLINK_HALF is lowered mid-count.
        if (r_blink_cnt >= r_blink_half) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 16'd1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign w_ch_wr[gi] = avs_write && (avs_address == ADDR_W'(ADDR_CH0 + gi));

    led_channel #(
      .DUTY_W (DUTY_W)
    ) u_ch (
      .clk           (clk_clk),
      .srst          (reset_reset),
      .i_wr          (w_ch_wr[gi]),
      .i_wdata       (avs_writedata[DUTY_W+1:0]),
      .i_en          (r_en),
      .i_pwm_cnt     (r_pwm_cnt),
      .i_blink_phase (r_blink_phase),
      .o_rdata       (w_ch_rdata[gi]),
      .o_led_next    (w_led_next[gi])
    );
  end

  always_comb begin
    w_rd_data = '0;
    if (avs_address == ADDR_W'(ADDR_CTRL)) begin
      w_rd_data[CTRL_EN_BIT] = r_en;
    end else if (avs_address == ADDR_W'(ADDR_PRESCALE)) begin
      w_rd_data[15:0] = r_prescale;
    end else if (avs_address == ADDR_W'(ADDR_BLINK)) begin
      w_rd_data[15:0] = r_blink_half;
    end else if (avs_address == ADDR_W'(ADDR_STATUS)) begin
      w_rd_data[STATUS_PWM_LSB +: DUTY_W] = r_pwm_cnt;
      w_rd_data[STATUS_PHASE_BIT]         = r_blink_phase;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (avs_address == ADDR_W'(ADDR_CH0 + i)) begin
        w_rd_data = w_ch_rdata[i];
      end
    end
  end

  // Read data is captured from pre-edge state, so a same-cycle write
  // to the same address returns the old contents.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      avs_readdata <= '0;
      leds_export  <= '0;
    end else begin
      if (avs_read) avs_readdata <= w_rd_data;
      leds_export <= w_led_next;
    end
  end

endmodule

// File: tb/tb_avmm_led_pwm_ctrl.sv
// Directed self-checking bench for avmm_led_pwm_ctrl with default parameters.
module tb_avmm_led_pwm_ctrl;

  logic        clk = 1'b0;
  logic        reset_reset;
  logic [4:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [7:0]  leds_export;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  avmm_led_pwm_ctrl #(
    .N_CH         (8),
    .DUTY_W       (8),
    .PRESCALE_RST (49),
    .ADDR_W       (5)
  ) dut (
    .clk_clk       (clk),
    .reset_reset   (reset_reset),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .leds_export   (leds_export)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic count_high(input int bit_i, input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (leds_export[bit_i]) cnt++;
    end
  endtask

  // Edges until leds_export[bit_i] reaches lvl; -1 if the bound expires.
  task automatic edges_to(input int bit_i, input logic lvl, input int limit, output int n);
    n = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk);
      #1;
      if (leds_export[bit_i] == lvl) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  v;
    logic [7:0]  base;
    logic [7:0]  base0;
    int c;
    int n;
    int first;
    int second;

    reset_reset   = 1'b1;
    avs_address   = 5'd0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset leds", 32'(leds_export), 32'd0);
    check("reset readdata", avs_readdata, 32'd0);
    reset_reset = 1'b0;

    bus_read(5'd1, d);
    check("prescale reset value", d, 32'd49);
    repeat (3) @(posedge clk);
    #1;
    check("readdata holds", avs_readdata, 32'd49);
    bus_read(5'd4, d);
    check("ch0 reset value", d, 32'd0);
    bus_read(5'd0, d);
    check("ctrl reset value", d, 32'd0);

    bus_write(5'd0, 32'hFFFF_FFFF);
    bus_read(5'd0, d);
    check("ctrl unused bits", d, 32'd1);
    bus_write(5'd4, 32'hFFFF_FFFF);
    bus_read(5'd4, d);
    check("ch0 unused bits", d, 32'h0000_03FF);

    bus_write(5'd4, 32'd1);
    bus_write(5'd5, 32'd1);
    bus_write(5'd5, 32'd0);
    check("leds at ch1 write edge", 32'(leds_export[1:0]), 32'd3);
    @(posedge clk);
    #1;
    check("leds one cycle after ch1 write", 32'(leds_export[1:0]), 32'd1);

    @(negedge clk);
    avs_address   = 5'd2;
    avs_writedata = 32'd5;
    avs_write     = 1'b1;
    avs_read      = 1'b1;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    avs_read  = 1'b0;
    check("same-cycle rd/wr old value", avs_readdata, 32'd0);
    bus_read(5'd2, d);
    check("blink_half new value", d, 32'd5);

    // PWM at one tick per cycle
    bus_write(5'd0, 32'd0);
    bus_write(5'd1, 32'd0);
    bus_write(5'd4, 32'd0);
    bus_write(5'd5, 32'd0);
    bus_write(5'd6, 32'h103);
    bus_write(5'd0, 32'd1);
    repeat (4) @(posedge clk);
    count_high(2, 512, c);
    check("pwm duty 64 highs/512", 32'(c), 32'd128);
    bus_write(5'd6, 32'h003);
    repeat (2) @(posedge clk);
    count_high(2, 512, c);
    check("pwm duty 0 highs/512", 32'(c), 32'd0);
    bus_write(5'd6, 32'h3FF);
    repeat (2) @(posedge clk);
    count_high(2, 512, c);
    check("pwm duty 255 highs/512", 32'(c), 32'd510);

    // Blink: 4-cycle ticks, phase toggles every 3 ticks
    bus_write(5'd0, 32'd0);
    bus_write(5'd6, 32'd0);
    bus_write(5'd1, 32'd3);
    bus_write(5'd2, 32'd2);
    bus_write(5'd7, 32'd2);
    bus_write(5'd0, 32'd1);
    edges_to(3, 1'b1, 40, n);
    check("blink first rise edges", 32'(n), 32'd13);
    edges_to(3, 1'b0, 40, n);
    check("blink fall after rise", 32'(n), 32'd12);
    edges_to(3, 1'b1, 40, n);
    check("blink rise after fall", 32'(n), 32'd12);

    // EN toggle mid-blink
    bus_write(5'd0, 32'd0);
    @(posedge clk);
    #1;
    check("leds off after EN=0", 32'(leds_export), 32'd0);
    bus_read(5'd3, d);
    check("status cleared by EN=0", d, 32'd0);
    bus_read(5'd7, d);
    check("ch3 kept across EN=0", d, 32'd2);
    bus_write(5'd0, 32'd1);
    edges_to(3, 1'b1, 40, n);
    check("blink restart rise edges", 32'(n), 32'd13);

    // Unmapped / read-only addresses
    bus_write(5'd0, 32'd0);
    bus_write(5'd3, 32'hFFFF_FFFF);
    bus_read(5'd3, d);
    check("status write ignored", d, 32'd0);
    bus_write(5'd31, 32'hFFFF_FFFF);
    bus_read(5'd31, d);
    check("unmapped addr 31 reads 0", d, 32'd0);

    // Lowering PRESCALE below the running count
    bus_write(5'd7, 32'd0);
    bus_write(5'd1, 32'd1000);
    bus_write(5'd0, 32'd1);
    repeat (500) @(posedge clk);
    bus_write(5'd1, 32'd10);
    avs_address = 5'd3;
    avs_read    = 1'b1;
    first  = -1;
    second = -1;
    base   = 8'd0;
    base0  = 8'hFF;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      v = avs_readdata[7:0];
      if (k == 1) begin
        base  = v;
        base0 = v;
      end else if (first < 0 && v != base) begin
        first = k;
        base  = v;
      end else if (first >= 0 && second < 0 && v != base) begin
        second = k;
      end
    end
    avs_read = 1'b0;
    check("pwm_cnt before lowered tick", 32'(base0), 32'd0);
    check("first tick after lowering", 32'(first), 32'd13);
    check("tick period after lowering", 32'(second - first), 32'd11);

    // Reset during PWM with a read pending
    bus_write(5'd1, 32'd0);
    bus_write(5'd6, 32'h203);
    repeat (100) @(posedge clk);
    @(negedge clk);
    reset_reset = 1'b1;
    avs_address = 5'd6;
    avs_read    = 1'b1;
    @(posedge clk);
    #1;
    reset_reset = 1'b0;
    avs_read    = 1'b0;
    check("read pending at reset", avs_readdata, 32'd0);
    check("leds at reset edge", 32'(leds_export), 32'd0);
    @(posedge clk);
    #1;
    check("leds after reset", 32'(leds_export), 32'd0);
    bus_read(5'd6, d);
    check("ch2 cleared by reset", d, 32'd0);
    bus_read(5'd1, d);
    check("prescale restored by reset", d, 32'd49);
    bus_read(5'd3, d);
    check("status cleared by reset", d, 32'd0);
    bus_read(5'd0, d);
    check("ctrl cleared by reset", d, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
